// File: rtl/regfile_dump_ctrl.sv
// Shares register file read port 1 between the pipeline and a debug dump that
// walks every register and streams each word LSB-byte-first over valid/ready.
module regfile_dump_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_core_addr,
  output logic [ADDR_WIDTH-1:0] o_rf_addr,
  input  logic [DATA_WIDTH-1:0] i_rf_data,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = '1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] reg_idx, reg_idx_next;
  logic [BCW-1:0]        byte_cnt, byte_cnt_next;
  logic [DATA_WIDTH-1:0] word_q, word_next;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      reg_idx  <= '0;
      byte_cnt <= '0;
      word_q   <= '0;
    end else begin
      state    <= state_next;
      reg_idx  <= reg_idx_next;
      byte_cnt <= byte_cnt_next;
      word_q   <= word_next;
    end
  end

  always_comb begin
    state_next    = state;
    reg_idx_next  = reg_idx;
    byte_cnt_next = byte_cnt;
    word_next     = word_q;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_next   = LOAD;
          reg_idx_next = '0;
        end
      end
      LOAD: begin
        word_next     = i_rf_data;
        byte_cnt_next = '0;
        state_next    = SEND;
      end
      SEND: begin
        if (i_tx_ready) begin
          word_next     = word_q >> 8;
          byte_cnt_next = byte_cnt + BCW'(1);
          if (byte_cnt == LAST_BYTE) begin
            // reg_idx saturates at the last register; DONE ends the walk
            if (reg_idx == LAST_IDX) begin
              state_next = DONE;
            end else begin
              reg_idx_next = reg_idx + ADDR_WIDTH'(1);
              state_next   = LOAD;
            end
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_rf_addr  = (state == IDLE) ? i_core_addr : reg_idx;
  assign o_tx_valid = (state == SEND);
  assign o_tx_data  = word_q[7:0];
  assign o_busy     = (state != IDLE);
  assign o_done     = (state == DONE);
endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl with a behavioural register file model.
module tb_regfile_dump_ctrl;
  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  core_addr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;
  logic        x3_override;

  int passed = 0;
  int total  = 0;

  int n, busy_cnt, done_cnt, done_cyc, addr_err, hold_err, stall_cnt, stall_err, byte_err;
  int finished, err;
  logic [7:0] bytes [0:127];
  logic       busy_at [0:199];
  logic       valid_at [0:199];
  logic       done_at [0:199];
  logic [4:0] addr_at [0:199];

  function automatic logic [31:0] reg_val(input int r, input logic ov);
    if (r == 0) return 32'h0;
    if (r == 3 && ov) return 32'hDEADBEEF;
    return 32'hA500_0000 + 32'(r);
  endfunction

  function automatic logic [7:0] exp_byte(input int i, input logic ov);
    logic [31:0] w;
    w = reg_val(i / 4, ov) >> (8 * (i % 4));
    return w[7:0];
  endfunction

  assign rf_data = reg_val(int'(rf_addr), x3_override);

  regfile_dump_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_core_addr(core_addr),
    .o_rf_addr  (rf_addr),
    .i_rf_data  (rf_data),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_busy     (busy),
    .o_done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", name, obs, exp);
  endtask

  // mode 0: ready always high; 1: random 50%; 2: ready low for the first 50 valid cycles
  task automatic dump_run(input int mode);
    logic prev_stall;
    logic [7:0] prev_data;
    int exp_idx;
    n = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0; addr_err = 0;
    hold_err = 0; stall_cnt = 0; stall_err = 0; byte_err = 0; finished = 0;
    prev_stall = 1'b0; prev_data = 8'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 2000 && finished == 0; c++) begin
      if (mode == 0) tx_ready = 1'b1;
      else if (mode == 1) tx_ready = 1'($urandom_range(0, 1));
      else if (tx_valid && stall_cnt < 50) begin
        tx_ready = 1'b0;
        stall_cnt++;
        if (tx_data !== 8'h00) stall_err++;
      end else tx_ready = 1'b1;
      core_addr = 5'($urandom);
      #1;
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) hold_err++;
      if (busy) begin
        busy_cnt++;
        exp_idx = (n / 4 > 31) ? 31 : n / 4;
        if (int'(rf_addr) != exp_idx) addr_err++;
      end
      if (tx_valid && tx_ready) begin
        if (n < 128) bytes[n] = tx_data;
        n++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (done) begin
        done_cnt++;
        done_cyc = c;
        finished = 1;
      end else begin
        @(negedge clk);
      end
    end
    for (int i = 0; i < 128 && i < n; i++)
      if (bytes[i] !== exp_byte(i, x3_override)) byte_err++;
    check("dump_finished", 32'(finished), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; core_addr = 5'd7; tx_ready = 1'b1; x3_override = 1'b0;
    #2;
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_addr", 32'(rf_addr), 32'd7);
    @(negedge clk);
    rst = 1'b0;

    // idle address passthrough
    err = 0;
    for (int a = 0; a < 32; a++) begin
      core_addr = 5'(a);
      #1;
      if (int'(rf_addr) != a) err++;
    end
    check("idle_addr_sweep", 32'(err), 32'd0);
    @(negedge clk);

    // full dump, ready held high
    dump_run(0);
    check("d1_count", 32'(n), 32'd128);
    check("d1_bytes", 32'(byte_err), 32'd0);
    check("d1_b4_7", {bytes[7], bytes[6], bytes[5], bytes[4]}, 32'hA5000001);
    check("d1_last4", {bytes[127], bytes[126], bytes[125], bytes[124]}, 32'hA500001F);
    check("d1_done_cyc", 32'(done_cyc), 32'd161);
    check("d1_busy_cnt", 32'(busy_cnt), 32'd161);
    check("d1_done_cnt", 32'(done_cnt), 32'd1);
    check("d1_addr_mux", 32'(addr_err), 32'd0);
    @(negedge clk);
    check("d1_idle_busy", 32'(busy), 32'd0);

    // random backpressure with x3 = DEADBEEF
    x3_override = 1'b1;
    dump_run(1);
    check("d2_count", 32'(n), 32'd128);
    check("d2_x3", {bytes[15], bytes[14], bytes[13], bytes[12]}, 32'hDEADBEEF);
    check("d2_b12", 32'(bytes[12]), 32'hEF);
    check("d2_bytes", 32'(byte_err), 32'd0);
    check("d2_hold", 32'(hold_err), 32'd0);
    check("d2_addr_mux", 32'(addr_err), 32'd0);
    x3_override = 1'b0;
    @(negedge clk);

    // async reset during SEND of register 10
    tx_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (52) @(negedge clk);
    check("r_pre_valid", 32'(tx_valid), 32'd1);
    check("r_pre_addr", 32'(rf_addr), 32'd10);
    #1 rst = 1'b1;
    #1;
    check("r_async_valid", 32'(tx_valid), 32'd0);
    check("r_async_busy", 32'(busy), 32'd0);
    err = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx_valid || done || busy) err++;
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (tx_valid || done || busy) err++;
    end
    check("r_quiet", 32'(err), 32'd0);
    dump_run(0);
    check("r_restart_count", 32'(n), 32'd128);
    check("r_restart_bytes", 32'(byte_err), 32'd0);
    @(negedge clk);

    // first byte stalled for 50 cycles
    dump_run(2);
    check("s_stall_cycles", 32'(stall_cnt), 32'd50);
    check("s_stall_data", 32'(stall_err), 32'd0);
    check("s_hold", 32'(hold_err), 32'd0);
    check("s_count", 32'(n), 32'd128);
    check("s_bytes", 32'(byte_err), 32'd0);
    check("s_done_cyc", 32'(done_cyc), 32'd211);
    @(negedge clk);

    // start held high: no restart while busy, retrigger after IDLE
    tx_ready = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 164; c++) begin
      @(negedge clk);
      #1;
      busy_at[c]  = busy;
      valid_at[c] = tx_valid;
      done_at[c]  = done;
      addr_at[c]  = rf_addr;
    end
    start = 1'b0;
    err = 0;
    for (int c = 1; c <= 161; c++) if (!busy_at[c]) err++;
    for (int c = 1; c <= 160; c++) if (done_at[c]) err++;
    check("h_busy_through", 32'(err), 32'd0);
    check("h_done161", 32'(done_at[161]), 32'd1);
    check("h_idle162", 32'(busy_at[162]), 32'd0);
    check("h_load163_busy", 32'(busy_at[163]), 32'd1);
    check("h_load163_valid", 32'(valid_at[163]), 32'd0);
    check("h_load163_addr", 32'(addr_at[163]), 32'd0);
    check("h_send164_valid", 32'(valid_at[164]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
